dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-port arbiter and sequencer in front of the byte-addressed 32-byte data memory. It shares the single memory port between requester 0 (the CPU load/store path) and requester 1 (a debug/preload port). It grants one request at a time with round-robin fairness and drives the memory's read/write strobes for exactly one cycle. It registers the result and returns a one-cycle acknowledge with read data or an error flag.

## Interface
- DEPTH, 32, memory size in bytes; a word access is legal iff addr ≤ DEPTH-4
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  asynchronous, active-low reset
- m0_req_i, m1_req_i  in  1  access request; hold high until matching ack
- m0_we_i, m1_we_i  in  1  1 = 32-bit write, 0 = 32-bit read
- m0_addr_i, m1_addr_i  in  32  byte address of lowest byte (little-endian word)
- m0_wdata_i, m1_wdata_i  in  32  write data
- m0_ack_o, m1_ack_o  out  1  one-cycle completion pulse
- m0_err_o, m1_err_o  out  1  valid with ack; 1 = out-of-range, no memory access made
- m0_rdata_o, m1_rdata_o  out  32  read data, valid with ack
- mem_addr_o  out  32  to memory addr_d
- mem_wdata_o  out  32  to memory write_data
- mem_read_o, mem_write_o  out  1  memory strobes
- mem_rdata_i  in  32  from memory read_data (combinational)
- busy_o  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: if no req, stay. Otherwise pick the winner, latch its we/addr/wdata and an owner bit, and go to ACCESS.
  - If only one requester has req high, it wins.
  - If both are high, the winner is the port not granted last.
- Round-robin pointer `last` updates at grant. Reset value is 1, so m0 wins the first contention.
- Range check at grant: err = (addr > DEPTH-4), computed as an unsigned 32-bit compare with no wrap. addr+3 is never formed.
- ACCESS, no error:
  - mem_addr_o = latched addr.
  - Write: mem_write_o = 1 and mem_wdata_o = latched wdata. The memory commits at the edge ending ACCESS.
  - Read: mem_read_o = 1, and mem_rdata_i is captured into the response register at the edge ending ACCESS.
- ACCESS with error: no strobe asserted. The response register is loaded with 0. The memory is untouched.
- RESP:
  - Owner's ack_o = 1 and err_o = the latched err.
  - Owner's rdata_o = captured data. Writes and errors return 0.
  - The other port's ack stays 0. Go to IDLE unconditionally.
- Strobes are 0 outside ACCESS. mem_read_o and mem_write_o are never high together.
- The requester drops req in the cycle ack is seen. A req still high in the cycle after ack is a new request.
- Request fields are sampled only at grant. Changes after grant are ignored.
- A non-owner's req is held pending, not lost.

## Timing
- Reset (rst_i low, asynchronous):
  - State returns to IDLE and last = 1.
  - All outputs are 0: acks, errs, rdata, mem strobes, mem_addr_o, mem_wdata_o, busy_o.
- Reset asserted during ACCESS deasserts mem_write_o immediately. The write is dropped, with no partial commit. Memory contents are not reset.
- Latency: req high in IDLE at edge N → ACCESS in cycle N+1 → ack in cycle N+2. Throughput is one access per 3 cycles.
- Back-to-back contention: both req high continuously gives grant order m0, m1, m0, m1, … One ack every 3 cycles, alternating.
- A request arriving while busy_o = 1 waits for the next IDLE.
- Read-after-write to the same address by either port returns the new data. The write commits before the next ACCESS.

## Test plan
- Reset mid-write:
  - Reset, then m0 writes 0xDEADBEEF @ addr 4 → ack in cycle 2, err = 0.
  - m0 reads @4 → rdata 0xDEADBEEF.
  - m1 reads @4 → 0xDEADBEEF.
  - Pull rst_i low during the ACCESS of a write of 0x11111111 @4, then read @4 → still 0xDEADBEEF, and all outputs were 0 during reset.
- Byte order: m1 writes 0x04030201 @ addr 1, then reads @0 → 0x03020100 when byte 0 was preloaded as 0x00. Confirms little-endian, unaligned-legal access.
- Contention: m0 and m1 raise read requests in the same cycle after reset → m0 acked first (cycle 2), m1 acked at cycle 5. Repeat with both held → alternation m0, m1, m0.
- Range check:
  - m0 reads @28 → err = 0.
  - m0 reads @29 → err = 1, rdata = 0, mem_read_o never high.
  - m1 writes @0xFFFFFFFE → err = 1, mem_write_o never high, memory unchanged.
- Sampling at grant: m0 writes @8, and m0_wdata_i is changed in the cycle after grant → memory holds the value present at grant. busy_o is high for exactly 2 cycles per access.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and sequencer sharing the single 32-byte data memory port
// between the CPU load/store path (m0) and the debug/preload port (m1).
module dmem_arbiter #(
  parameter int unsigned DEPTH = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m0_req_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wdata_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic [31:0] m0_rdata_o,
  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wdata_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] m1_rdata_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  input  logic [31:0] mem_rdata_i,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  // Highest legal word address; compared unsigned so no addr+3 overflow can occur.
  localparam logic [31:0] LAST_WORD = 32'(DEPTH - 32'd4);

  state_t      r_state;
  state_t      w_state_nx;
  logic        r_last;
  logic        r_owner;
  logic        r_we;
  logic        r_err;

  logic        w_grant;
  logic        w_win;
  logic        w_sel_we;
  logic        w_sel_err;
  logic [31:0] w_sel_addr;
  logic [31:0] w_sel_wdata;
  logic [31:0] w_resp_data;

  logic        r_mem_read;
  logic        r_mem_write;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic        r_ack0;
  logic        r_ack1;
  logic        r_err0;
  logic        r_err1;
  logic [31:0] r_rdata0;
  logic [31:0] r_rdata1;
  logic        r_busy;

  logic        w_mem_read_nx;
  logic        w_mem_write_nx;
  logic [31:0] w_mem_addr_nx;
  logic [31:0] w_mem_wdata_nx;
  logic        w_ack0_nx;
  logic        w_ack1_nx;
  logic        w_err0_nx;
  logic        w_err1_nx;
  logic [31:0] w_rdata0_nx;
  logic [31:0] w_rdata1_nx;
  logic        w_busy_nx;

  // Winner selection: lone requester wins, contention goes to the port not granted last.
  always_comb begin
    w_win       = (m0_req_i && m1_req_i) ? ~r_last : m1_req_i;
    w_sel_we    = w_win ? m1_we_i    : m0_we_i;
    w_sel_addr  = w_win ? m1_addr_i  : m0_addr_i;
    w_sel_wdata = w_win ? m1_wdata_i : m0_wdata_i;
    w_sel_err   = (w_sel_addr > LAST_WORD);
    w_resp_data = (!r_err && !r_we) ? mem_rdata_i : 32'd0;
  end

  // Next-state and next-output decode; outputs are registered one cycle ahead.
  always_comb begin
    w_state_nx     = r_state;
    w_grant        = 1'b0;
    w_mem_read_nx  = 1'b0;
    w_mem_write_nx = 1'b0;
    w_mem_addr_nx  = 32'd0;
    w_mem_wdata_nx = 32'd0;
    w_ack0_nx      = 1'b0;
    w_ack1_nx      = 1'b0;
    w_err0_nx      = 1'b0;
    w_err1_nx      = 1'b0;
    w_rdata0_nx    = 32'd0;
    w_rdata1_nx    = 32'd0;
    w_busy_nx      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (m0_req_i || m1_req_i) begin
          w_grant        = 1'b1;
          w_state_nx     = ST_ACCESS;
          w_busy_nx      = 1'b1;
          w_mem_read_nx  = !w_sel_err && !w_sel_we;
          w_mem_write_nx = !w_sel_err && w_sel_we;
          w_mem_addr_nx  = w_sel_err ? 32'd0 : w_sel_addr;
          w_mem_wdata_nx = (!w_sel_err && w_sel_we) ? w_sel_wdata : 32'd0;
        end else begin
          w_state_nx = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        w_state_nx  = ST_RESP;
        w_busy_nx   = 1'b1;
        w_ack0_nx   = !r_owner;
        w_ack1_nx   = r_owner;
        w_err0_nx   = !r_owner && r_err;
        w_err1_nx   = r_owner && r_err;
        w_rdata0_nx = r_owner ? 32'd0 : w_resp_data;
        w_rdata1_nx = r_owner ? w_resp_data : 32'd0;
      end
      ST_RESP: begin
        w_state_nx = ST_IDLE;
      end
      default: begin
        w_state_nx = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Grant-time capture of the winning request and round-robin pointer.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_last  <= 1'b1;
      r_owner <= 1'b0;
      r_we    <= 1'b0;
      r_err   <= 1'b0;
    end else if (w_grant) begin
      r_last  <= w_win;
      r_owner <= w_win;
      r_we    <= w_sel_we;
      r_err   <= w_sel_err;
    end else begin
      r_last  <= r_last;
      r_owner <= r_owner;
      r_we    <= r_we;
      r_err   <= r_err;
    end
  end

  // Output registers; async reset drops any strobe mid-access with no partial commit.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= 32'd0;
      r_mem_wdata <= 32'd0;
      r_ack0      <= 1'b0;
      r_ack1      <= 1'b0;
      r_err0      <= 1'b0;
      r_err1      <= 1'b0;
      r_rdata0    <= 32'd0;
      r_rdata1    <= 32'd0;
      r_busy      <= 1'b0;
    end else begin
      r_mem_read  <= w_mem_read_nx;
      r_mem_write <= w_mem_write_nx;
      r_mem_addr  <= w_mem_addr_nx;
      r_mem_wdata <= w_mem_wdata_nx;
      r_ack0      <= w_ack0_nx;
      r_ack1      <= w_ack1_nx;
      r_err0      <= w_err0_nx;
      r_err1      <= w_err1_nx;
      r_rdata0    <= w_rdata0_nx;
      r_rdata1    <= w_rdata1_nx;
      r_busy      <= w_busy_nx;
    end
  end

  assign mem_read_o  = r_mem_read;
  assign mem_write_o = r_mem_write;
  assign mem_addr_o  = r_mem_addr;
  assign mem_wdata_o = r_mem_wdata;
  assign m0_ack_o    = r_ack0;
  assign m1_ack_o    = r_ack1;
  assign m0_err_o    = r_err0;
  assign m1_err_o    = r_err1;
  assign m0_rdata_o  = r_rdata0;
  assign m1_rdata_o  = r_rdata1;
  assign busy_o      = r_busy;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a little-endian 32-byte memory model.
module tb_dmem_arbiter;

  logic        clk_i;
  logic        rst_i;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic [31:0] m0_rdata_o, m1_rdata_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata;
  logic        mem_read_o, mem_write_o, busy_o;

  logic [7:0]  mem [0:31];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_rd = 0;
  int          n_wr = 0;
  int          n_busy = 0;
  int          n_both = 0;

  dmem_arbiter #(.DEPTH(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
    .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_rdata_o(m0_rdata_o),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
    .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_rdata_o(m1_rdata_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
    .mem_rdata_i(mem_rdata), .busy_o(busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  always_ff @(posedge clk_i) begin
    if (mem_write_o) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_addr_o + 32'(b) < 32'd32) mem[5'(mem_addr_o + 32'(b))] <= mem_wdata_o[8*b +: 8];
      end
    end
  end

  always_comb begin
    mem_rdata = 32'd0;
    for (int b = 0; b < 4; b++) begin
      if (mem_addr_o + 32'(b) < 32'd32) mem_rdata[8*b +: 8] = mem[5'(mem_addr_o + 32'(b))];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] outs_or();
    return m0_rdata_o | m1_rdata_o | mem_addr_o | mem_wdata_o |
           {25'd0, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o, mem_read_o, mem_write_o, busy_o};
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
    if (mem_read_o) n_rd++;
    if (mem_write_o) n_wr++;
    if (busy_o) n_busy++;
    if (mem_read_o && mem_write_o) n_both++;
  endtask

  task automatic xact(input bit port, input logic we, input logic [31:0] addr,
                      input logic [31:0] wd, output logic [31:0] rd, output logic er,
                      output int lat);
    bit done = 1'b0;
    rd = 32'd0;
    er = 1'b0;
    lat = 0;
    if (port) begin
      m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = wd;
    end else begin
      m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wdata = wd;
    end
    while (!done && lat < 10) begin
      step();
      lat++;
      if (port ? m1_ack_o : m0_ack_o) begin
        done = 1'b1;
        rd = port ? m1_rdata_o : m0_rdata_o;
        er = port ? m1_err_o : m0_err_o;
      end
    end
    m0_req = 1'b0;
    m1_req = 1'b0;
    step();
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          b0;
    int          w0;
    int          r0;
    logic [15:0] a0;
    logic [15:0] a1;

    rst_i = 1'b0;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = 32'd0; m0_wdata = 32'd0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = 32'd0; m1_wdata = 32'd0;
    repeat (3) step();
    chk("reset_outputs_zero", outs_or(), 32'd0);
    rst_i = 1'b1;
    step();

    // Basic write/read by both ports
    w0 = n_wr; b0 = n_busy;
    xact(1'b0, 1'b1, 32'd4, 32'hDEADBEEF, rd, er, lat);
    chk("w4_latency", 32'(lat), 32'd2);
    chk("w4_err", {31'd0, er}, 32'd0);
    chk("w4_strobes", 32'(n_wr - w0), 32'd1);
    chk("w4_busy_cycles", 32'(n_busy - b0), 32'd2);
    chk("ack_one_cycle", {30'd0, m0_ack_o, m1_ack_o}, 32'd0);
    xact(1'b0, 1'b0, 32'd4, 32'd0, rd, er, lat);
    chk("m0_r4_data", rd, 32'hDEADBEEF);
    xact(1'b1, 1'b0, 32'd4, 32'd0, rd, er, lat);
    chk("m1_r4_data", rd, 32'hDEADBEEF);
    chk("m1_r4_latency", 32'(lat), 32'd2);

    // Reset in the middle of a write
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'd4; m0_wdata = 32'h11111111;
    step();
    chk("rw_write_strobe", {31'd0, mem_write_o}, 32'd1);
    #3 rst_i = 1'b0;
    #1;
    chk("rw_strobe_dropped", {31'd0, mem_write_o}, 32'd0);
    chk("rw_outputs_zero", outs_or(), 32'd0);
    m0_req = 1'b0;
    step();
    chk("rw_outputs_zero_edge", outs_or(), 32'd0);
    rst_i = 1'b1;
    step();
    xact(1'b0, 1'b0, 32'd4, 32'd0, rd, er, lat);
    chk("rw_no_commit", rd, 32'hDEADBEEF);

    // Byte order and unaligned access
    xact(1'b1, 1'b1, 32'd0, 32'h00000000, rd, er, lat);
    xact(1'b1, 1'b1, 32'd1, 32'h04030201, rd, er, lat);
    chk("unaligned_w1_err", {31'd0, er}, 32'd0);
    xact(1'b1, 1'b0, 32'd0, 32'd0, rd, er, lat);
    chk("little_endian_r0", rd, 32'h03020100);

    // Contention after reset, both held: m0, m1, m0, m1
    rst_i = 1'b0;
    step();
    rst_i = 1'b1;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'd0;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'd4;
    a0 = 16'd0; a1 = 16'd0;
    for (int i = 1; i <= 12; i++) begin
      step();
      a0[i] = m0_ack_o;
      a1[i] = m1_ack_o;
      if (i == 2) chk("cont_m0_rdata", m0_rdata_o, 32'h03020100);
      if (i == 5) chk("cont_m1_rdata", m1_rdata_o, 32'hDEADBE04);
    end
    chk("cont_m0_ack_cycles", {16'd0, a0}, 32'h00000104);
    chk("cont_m1_ack_cycles", {16'd0, a1}, 32'h00000820);
    m0_req = 1'b0; m1_req = 1'b0;
    step();
    chk("cont_idle", {31'd0, busy_o}, 32'd0);

    // Range check
    xact(1'b0, 1'b1, 32'd28, 32'hA5A55A5A, rd, er, lat);
    r0 = n_rd;
    xact(1'b0, 1'b0, 32'd28, 32'd0, rd, er, lat);
    chk("r28_err", {31'd0, er}, 32'd0);
    chk("r28_data", rd, 32'hA5A55A5A);
    chk("r28_strobe", 32'(n_rd - r0), 32'd1);
    r0 = n_rd;
    xact(1'b0, 1'b0, 32'd29, 32'd0, rd, er, lat);
    chk("r29_err", {31'd0, er}, 32'd1);
    chk("r29_data", rd, 32'd0);
    chk("r29_no_strobe", 32'(n_rd - r0), 32'd0);
    chk("r29_latency", 32'(lat), 32'd2);
    w0 = n_wr;
    xact(1'b1, 1'b1, 32'hFFFFFFFE, 32'h99999999, rd, er, lat);
    chk("wfffe_err", {31'd0, er}, 32'd1);
    chk("wfffe_no_strobe", 32'(n_wr - w0), 32'd0);
    xact(1'b0, 1'b0, 32'd28, 32'd0, rd, er, lat);
    chk("wfffe_mem_unchanged", rd, 32'hA5A55A5A);

    // Request fields sampled only at grant
    b0 = n_busy;
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'd8; m0_wdata = 32'h12345678;
    step();
    m0_wdata = 32'hCAFEF00D;
    m0_addr = 32'd12;
    #1;
    chk("sg_wdata_held", mem_wdata_o, 32'h12345678);
    chk("sg_addr_held", mem_addr_o, 32'd8);
    step();
    chk("sg_ack", {31'd0, m0_ack_o}, 32'd1);
    m0_req = 1'b0;
    step();
    chk("sg_busy_cycles", 32'(n_busy - b0), 32'd2);
    xact(1'b0, 1'b0, 32'd8, 32'd0, rd, er, lat);
    chk("sg_r8_data", rd, 32'h12345678);

    chk("strobes_exclusive", 32'(n_both), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
